// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit peripheral:
// register offsets, STATUS bit positions and FSM state encoding.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // A zero divisor would never finish a bit, so it is stored as 1.
    function automatic logic [15:0] div_sanitize(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push at full is
// accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register file, FIFO,
// baud counter and frame FSM.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [31:0] dataBus_Write,
    output logic [31:0] dataBus_Read,
    output logic        TX,
    output logic        IRQ
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic        wr, rd;
    logic [1:0]  a;
    logic        push, pop;
    logic        full, empty;
    logic [7:0]  head;
    logic [AW:0] fifo_count;
    logic        ovf_set;
    logic        busy;
    logic [31:0] status_w;

    logic [31:0] rdata_q, rdata_d;
    logic [15:0] div_q, div_d;
    logic        ctrl_q, ctrl_d;
    logic        ovf_q, ovf_d;

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_act_q, div_act_d;
    logic        tx_q, tx_d;
    logic        baud_done;

    logic        unused_ok;
    assign unused_ok = ^{ADDR[31:2], dataBus_Write[31:16]};

    assign wr   = CS & WE;
    assign rd   = CS & ~WE;
    assign a    = ADDR[1:0];
    assign push = wr && (a == REG_DATA);
    assign ovf_set = push & full & ~pop;
    assign busy = (state_q != S_IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .wdata (dataBus_Write[7:0]),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_comb begin
        status_w = '0;
        status_w[ST_FULL]  = full;
        status_w[ST_EMPTY] = empty;
        status_w[ST_BUSY]  = busy;
        status_w[ST_OVF]   = ovf_q;
        status_w[ST_CNT +: 4] = 4'(fifo_count);
    end

    always_comb begin
        rdata_d = rdata_q;
        div_d   = div_q;
        ctrl_d  = ctrl_q;
        ovf_d   = ovf_q;
        if (wr && a == REG_DIV) begin
            div_d = div_sanitize(dataBus_Write[15:0]);
        end
        if (wr && a == REG_CTRL) begin
            ctrl_d = dataBus_Write[0];
        end
        if (rd) begin
            unique case (a)
                REG_DATA:   rdata_d = '0;
                REG_STATUS: rdata_d = status_w;
                REG_DIV:    rdata_d = {16'd0, div_q};
                REG_CTRL:   rdata_d = {31'd0, ctrl_q};
            endcase
        end
        // Set beats clear when both land on the same edge.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (rd && a == REG_STATUS) begin
            ovf_d = 1'b0;
        end
    end

    assign baud_done = (baud_q == div_act_q - 16'd1);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        div_act_d = div_act_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = head;
                    div_act_d = div_q;
                    baud_d    = '0;
                    tx_d      = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_d   = head;
                        div_act_d = div_q;
                        tx_d      = 1'b0;
                        state_d   = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q   <= '0;
            div_q     <= 16'(CLK_DIV);
            ctrl_q    <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            div_act_q <= 16'(CLK_DIV);
            tx_q      <= 1'b1;
        end else begin
            rdata_q   <= rdata_d;
            div_q     <= div_d;
            ctrl_q    <= ctrl_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            div_act_q <= div_act_d;
            tx_q      <= tx_d;
        end
    end

    assign dataBus_Read = rdata_q;
    assign TX  = tx_q;
    assign IRQ = ctrl_q & empty;

endmodule
